// File: rtl/mul8s_share_arb_if.sv
// Request, result and shared-multiplier buses of mul8s_share_arb.
// The slave modport is the arbiter; master is the environment (lanes, multiplier, consumer).
interface mul8s_share_arb_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [8*NREQ-1:0] req_a;
   logic [8*NREQ-1:0] req_b;
   logic [7:0]        mul_a;
   logic [7:0]        mul_b;
   logic [15:0]       mul_o;
   logic              res_valid;
   logic              res_ready;
   logic [15:0]       res_data;
   logic [IDW-1:0]    res_id;

   modport slave (
      input  req_valid, req_a, req_b, mul_o, res_ready,
      output req_ready, mul_a, mul_b, res_valid, res_data, res_id
   );

   modport master (
      output req_valid, req_a, req_b, mul_o, res_ready,
      input  req_ready, mul_a, mul_b, res_valid, res_data, res_id
   );
endinterface

// File: rtl/mul8s_share_arb.sv
// Round-robin arbiter time-sharing one 8x8 signed multiplier between NREQ lanes,
// with a registered operand stage and a registered result stage.
module mul8s_share_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   mul8s_share_arb_if.slave        bus,
   output logic                    busy,
   output logic [15:0]             op_cnt
);
   localparam int unsigned NR = NREQ;

   logic           op_vld_q, op_vld_d;
   logic [7:0]     op_a_q, op_a_d;
   logic [7:0]     op_b_q, op_b_d;
   logic [IDW-1:0] op_id_q, op_id_d;
   logic           res_valid_q, res_valid_d;
   logic [15:0]    res_data_q, res_data_d;
   logic [IDW-1:0] res_id_q, res_id_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [15:0]    op_cnt_q, op_cnt_d;

   logic           adv_res, adv_op, found, accept;
   logic [IDW-1:0] win, cand;

   assign adv_res = !res_valid_q || bus.res_ready;
   assign adv_op  = !op_vld_q || adv_res;

   // Search ptr+1 .. ptr+NREQ (mod NREQ); the last candidate is ptr itself.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int unsigned k = 1; k <= NR; k++) begin
         cand = IDW'((32'(ptr_q) + k) % NR);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign accept = found && adv_op && !rst;

   always_comb begin
      bus.req_ready = '0;
      if (accept) bus.req_ready[win] = 1'b1;
   end

   always_comb begin
      op_vld_d    = op_vld_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_id_d     = op_id_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_id_d    = res_id_q;
      ptr_d       = ptr_q;
      op_cnt_d    = op_cnt_q;

      if (op_vld_q && adv_res) begin
         res_valid_d = 1'b1;
         res_data_d  = bus.mul_o;
         res_id_d    = op_id_q;
         op_vld_d    = 1'b0;
      end else if (res_valid_q && bus.res_ready) begin
         res_valid_d = 1'b0;
      end

      if (accept) begin
         op_vld_d = 1'b1;
         op_a_d   = bus.req_a[8*win +: 8];
         op_b_d   = bus.req_b[8*win +: 8];
         op_id_d  = win;
         ptr_d    = win;
         op_cnt_d = op_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_vld_q    <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_id_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_id_q    <= '0;
         ptr_q       <= '0;
         op_cnt_q    <= '0;
      end else begin
         op_vld_q    <= op_vld_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_id_q     <= op_id_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_id_q    <= res_id_d;
         ptr_q       <= ptr_d;
         op_cnt_q    <= op_cnt_d;
      end
   end

   assign bus.mul_a     = op_a_q;
   assign bus.mul_b     = op_b_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_id    = res_id_q;
   assign busy          = op_vld_q || res_valid_q;
   assign op_cnt        = op_cnt_q;
endmodule

// File: tb/tb_mul8s_share_arb.sv
// Directed bench for mul8s_share_arb: a negedge monitor pushes expected products at each
// request handshake and pops/compares them at each result handshake.
module tb_mul8s_share_arb;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [15:0]    data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        busy;
   logic [15:0] op_cnt;
   logic        beef_mode = 1'b0;

   int n_asserts = 0;
   int n_fail    = 0;
   int n_acc     = 0;
   int n_res     = 0;

   exp_t sb[$];
   int   grants[$];

   mul8s_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   mul8s_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus.slave),
      .busy   (busy),
      .op_cnt (op_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
      logic signed [15:0] sa, sb2;
      sa  = {{8{a[7]}}, a};
      sb2 = {{8{b[7]}}, b};
      return sa * sb2;
   endfunction

   assign bus.mul_o = beef_mode ? 16'hBEEF : smul(bus.mul_a, bus.mul_b);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b);
      bus.req_a[8*i +: 8] = a;
      bus.req_b[8*i +: 8] = b;
   endtask

   // Handshakes are sampled mid-cycle; they complete at the following rising edge.
   always @(negedge clk) begin
      exp_t e;
      logic [7:0] a, b;
      if (!rst) begin
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
               a = bus.req_a[8*i +: 8];
               b = bus.req_b[8*i +: 8];
               e.id   = IDW'(i);
               e.data = beef_mode ? 16'hBEEF : smul(a, b);
               sb.push_back(e);
               grants.push_back(i);
               n_acc++;
            end
         end
         if (bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("res_data", 32'(bus.res_data), 32'(e.data));
               check("res_id", 32'(bus.res_id), 32'(e.id));
            end
            n_res++;
         end
      end
   end

   initial begin
      logic [15:0]    hold_data;
      logic [IDW-1:0] hold_id;
      int acc0, res0, cycles;

      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.res_ready = 1'b0;

      // Reset state, with requests pending to show req_ready is held low.
      rst = 1'b1;
      bus.req_valid = 4'hF;
      tick();
      tick();
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_res_valid", 32'(bus.res_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_op_cnt", 32'(op_cnt), 32'h0);
      check("rst_mul_a", 32'(bus.mul_a), 32'h0);
      check("rst_mul_b", 32'(bus.mul_b), 32'h0);
      check("rst_res_data", 32'(bus.res_data), 32'h0);
      check("rst_res_id", 32'(bus.res_id), 32'h0);
      bus.req_valid = '0;
      rst = 1'b0;
      tick();

      // Single request on lane 2.
      set_lane(2, 8'hFD, 8'h05);
      bus.res_ready = 1'b1;
      bus.req_valid = 4'b0100;
      #1;
      check("single_ready", 32'(bus.req_ready), 32'h4);
      tick();
      bus.req_valid = '0;
      check("single_mul_a", 32'(bus.mul_a), 32'hFD);
      check("single_mul_b", 32'(bus.mul_b), 32'h05);
      check("single_res_valid_early", 32'(bus.res_valid), 32'h0);
      check("single_op_cnt", 32'(op_cnt), 32'h1);
      tick();
      check("single_res_valid", 32'(bus.res_valid), 32'h1);
      check("single_res_data", 32'(bus.res_data), 32'hFFF1);
      check("single_res_id", 32'(bus.res_id), 32'h2);
      tick();
      check("single_busy_after", 32'(busy), 32'h0);
      check("single_sb_empty", 32'(sb.size()), 32'h0);

      // All lanes continuously from reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      grants.delete();
      res0 = n_res;
      for (int i = 0; i < NREQ; i++) set_lane(i, 8'($urandom), 8'($urandom));
      bus.req_valid = 4'hF;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (c >= 1) check("all_res_valid", 32'(bus.res_valid), 32'h1);
         for (int i = 0; i < NREQ; i++) set_lane(i, 8'($urandom), 8'($urandom));
      end
      bus.req_valid = '0;
      tick();
      tick();
      tick();
      check("all_grant_count", 32'(grants.size()), 32'd12);
      for (int i = 0; i < grants.size(); i++)
         check("all_grant_order", 32'(grants[i]), 32'((i + 1) % NREQ));
      check("all_results", 32'(n_res - res0), 32'd12);

      // Backpressure with lanes 0 and 1 (ptr now 0, so lane 1 first).
      grants.delete();
      set_lane(0, 8'h12, 8'hF0);
      set_lane(1, 8'h7F, 8'h81);
      bus.res_ready = 1'b0;
      bus.req_valid = 4'b0011;
      #1;
      check("bp_ready0", 32'(bus.req_ready), 32'h2);
      tick();
      check("bp_ready1", 32'(bus.req_ready), 32'h1);
      tick();
      check("bp_ready_blocked", 32'(bus.req_ready), 32'h0);
      hold_data = bus.res_data;
      hold_id   = bus.res_id;
      check("bp_hold_id", 32'(hold_id), 32'h1);
      tick();
      tick();
      tick();
      check("bp_accepts", 32'(grants.size()), 32'd2);
      check("bp_ready_end", 32'(bus.req_ready), 32'h0);
      check("bp_data_stable", 32'(bus.res_data), 32'(hold_data));
      check("bp_id_stable", 32'(bus.res_id), 32'(hold_id));
      check("bp_mul_a_held", 32'(bus.mul_a), 32'h12);
      bus.req_valid = '0;
      bus.res_ready = 1'b1;
      tick();
      check("bp_rel_valid1", 32'(bus.res_valid), 32'h1);
      check("bp_rel_id1", 32'(bus.res_id), 32'h0);
      tick();
      check("bp_rel_valid2", 32'(bus.res_valid), 32'h0);
      check("bp_sb_empty", 32'(sb.size()), 32'h0);

      // Reset with both stages full.
      bus.res_ready = 1'b0;
      bus.req_valid = 4'b0001;
      tick();
      tick();
      bus.req_valid = '0;
      check("rmo_full_busy", 32'(busy), 32'h1);
      check("rmo_full_res_valid", 32'(bus.res_valid), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      check("rmo_res_valid", 32'(bus.res_valid), 32'h0);
      check("rmo_busy", 32'(busy), 32'h0);
      check("rmo_op_cnt", 32'(op_cnt), 32'h0);
      set_lane(0, 8'h03, 8'h04);
      set_lane(3, 8'hC0, 8'h02);
      bus.res_ready = 1'b1;
      bus.req_valid = 4'b1001;
      #1;
      check("rmo_first_grant", 32'(bus.req_ready), 32'h8);
      tick();
      check("rmo_second_grant", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = '0;
      tick();
      tick();
      check("rmo_sb_empty", 32'(sb.size()), 32'h0);

      // Extreme operands with a product the bench multiplier makes up.
      beef_mode = 1'b1;
      set_lane(0, 8'h80, 8'h80);
      bus.req_valid = 4'b0001;
      #1;
      check("ext_ready", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = '0;
      check("ext_mul_a", 32'(bus.mul_a), 32'h80);
      check("ext_mul_b", 32'(bus.mul_b), 32'h80);
      tick();
      check("ext_res_valid", 32'(bus.res_valid), 32'h1);
      check("ext_res_data", 32'(bus.res_data), 32'hBEEF);
      tick();
      beef_mode = 1'b0;
      check("ext_sb_empty", 32'(sb.size()), 32'h0);

      // op_cnt wrap after 65537 accepts, one per cycle.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      grants.delete();
      for (int i = 0; i < NREQ; i++) set_lane(i, 8'(i * 37 + 5), 8'(i * 11 + 250));
      acc0 = n_acc;
      cycles = 0;
      bus.req_valid = 4'hF;
      while ((n_acc - acc0) < 65537 && cycles < 70000) begin
         tick();
         cycles++;
      end
      bus.req_valid = '0;
      check("wrap_cycles", 32'(cycles), 32'd65537);
      check("wrap_op_cnt", 32'(op_cnt), 32'h1);
      tick();
      tick();
      tick();
      check("wrap_sb_empty", 32'(sb.size()), 32'h0);
      check("wrap_idle", 32'(busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
